// File: rtl/f1_light_monitor.sv
// f1_light_monitor: receiving end of the F1 start-light bar.
// Checks that the thermometer-coded light vector builds up one light at a
// time, detects the all-on -> all-off "lights out" event, then measures the
// driver's reaction time in clk cycles up to the next button press.
// Jump starts (press before lights out) and illegal light sequences are
// reported as one-cycle pulses.
// Optional feature macro: F1_MON_BEST_EN (tracks the best reaction since reset).
module f1_light_monitor #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] lights_in,
  input  logic             btn,
  output logic             armed,
  output logic             timing,
  output logic [CNT_W-1:0] reaction_time,
  output logic             result_valid,
  output logic             jump_start,
  output logic             seq_error,
  output logic [CNT_W-1:0] best_time
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_BUILD  = 2'd1,
    S_ALL_ON = 2'd2,
    S_TIMING = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0] LIGHT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  state_t           state_q, state_d;
  logic [WIDTH-1:0] prev_q;
  logic             btn_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] reaction_q, reaction_d;
  logic             armed_q, timing_q;
  logic             result_valid_q, result_valid_d;
  logic             jump_start_q, jump_start_d;
  logic             seq_error_q, seq_error_d;

  logic press;
  logic step;
  logic hold;
  logic all_on;
  logic all_off;

  // A non-thermometer pattern outside IDLE is never a hold or a step, so
  // it falls into the seq_error branch of every armed/timing state.
  assign press   = btn & ~btn_q;
  assign step    = (lights_in == {prev_q[WIDTH-2:0], 1'b1});
  assign hold    = (lights_in == prev_q);
  assign all_on  = &lights_in;
  assign all_off = ~|lights_in;

  // Next-state, counter and pulse decode; press has priority in every state.
  always_comb begin
    state_d        = state_q;
    count_d        = count_q;
    reaction_d     = reaction_q;
    result_valid_d = 1'b0;
    jump_start_d   = 1'b0;
    seq_error_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if ((lights_in == LIGHT_ONE) && (prev_q == {WIDTH{1'b0}})) begin
          state_d = S_BUILD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BUILD: begin
        if (press) begin
          jump_start_d = 1'b1;
          state_d      = S_IDLE;
        end else if (hold) begin
          state_d = S_BUILD;
        end else if (step && all_on) begin
          state_d = S_ALL_ON;
        end else if (step) begin
          state_d = S_BUILD;
        end else begin
          seq_error_d = 1'b1;
          state_d     = S_IDLE;
        end
      end
      S_ALL_ON: begin
        if (press) begin
          jump_start_d = 1'b1;
          state_d      = S_IDLE;
        end else if (all_off) begin
          state_d = S_TIMING;
          count_d = CNT_ONE;
        end else if (hold) begin
          state_d = S_ALL_ON;
        end else begin
          seq_error_d = 1'b1;
          state_d     = S_IDLE;
        end
      end
      S_TIMING: begin
        if (press) begin
          reaction_d     = count_q;
          result_valid_d = 1'b1;
          state_d        = S_IDLE;
        end else if (!all_off) begin
          seq_error_d = 1'b1;
          state_d     = S_IDLE;
        end else if (count_q != CNT_MAX) begin
          count_d = count_q + CNT_ONE;
        end else begin
          count_d = count_q;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, sampling registers and registered output decodes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      prev_q         <= {WIDTH{1'b0}};
      btn_q          <= 1'b0;
      count_q        <= {CNT_W{1'b0}};
      reaction_q     <= {CNT_W{1'b0}};
      armed_q        <= 1'b0;
      timing_q       <= 1'b0;
      result_valid_q <= 1'b0;
      jump_start_q   <= 1'b0;
      seq_error_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      prev_q         <= lights_in;
      btn_q          <= btn;
      count_q        <= count_d;
      reaction_q     <= reaction_d;
      armed_q        <= (state_d == S_BUILD) || (state_d == S_ALL_ON);
      timing_q       <= (state_d == S_TIMING);
      result_valid_q <= result_valid_d;
      jump_start_q   <= jump_start_d;
      seq_error_q    <= seq_error_d;
    end
  end

`ifdef F1_MON_BEST_EN
  logic [CNT_W-1:0] best_q;

  // Best reaction tracks the new result in the same cycle reaction_time loads.
  always_ff @(posedge clk) begin
    if (rst) begin
      best_q <= CNT_MAX;
    end else if (result_valid_d && (count_q < best_q)) begin
      best_q <= count_q;
    end else begin
      best_q <= best_q;
    end
  end

  assign best_time = best_q;
`else
  assign best_time = CNT_MAX;
`endif

  assign armed         = armed_q;
  assign timing        = timing_q;
  assign reaction_time = reaction_q;
  assign result_valid  = result_valid_q;
  assign jump_start    = jump_start_q;
  assign seq_error     = seq_error_q;

endmodule

// File: tb/tb_f1_light_monitor.sv
// Bench for f1_light_monitor: directed scenarios plus randomized light runs,
// checked every cycle against a behavioural model that works in terms of
// lit-light counts and cycle stamps. A second instance with CNT_W=4 shares
// the stimulus to exercise counter saturation.
module tb_f1_light_monitor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  lights = 8'd0;
  logic        btn = 1'b0;

  logic        armed16, timing16, rv16, js16, se16;
  logic [15:0] rt16, best16;
  logic        armed4, timing4, rv4, js4, se4;
  logic [3:0]  rt4, best4;

  int total = 0;
  int bad   = 0;

  // model state
  int          m_phase = 0;   // 0 idle, 1 building, 2 all on, 3 timing
  logic [7:0]  m_prev = 8'd0;
  logic        m_btnq = 1'b0;
  int          m_cyc = 0;
  int          m_lo = 0;
  logic        e_armed = 1'b0, e_timing = 1'b0, e_rv = 1'b0, e_js = 1'b0, e_se = 1'b0;
  int          e_rt16 = 0, e_rt4 = 0, e_b16 = 65535, e_b4 = 15;

  f1_light_monitor #(.WIDTH(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .lights_in(lights), .btn(btn),
    .armed(armed16), .timing(timing16), .reaction_time(rt16),
    .result_valid(rv16), .jump_start(js16), .seq_error(se16), .best_time(best16)
  );

  f1_light_monitor #(.WIDTH(8), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .lights_in(lights), .btn(btn),
    .armed(armed4), .timing(timing4), .reaction_time(rt4),
    .result_valid(rv4), .jump_start(js4), .seq_error(se4), .best_time(best4)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] therm(input int n);
    logic [8:0] v;
    v = (9'd1 << n) - 9'd1;
    return v[7:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // reference model: one sampled cycle
  task automatic model(input logic [7:0] l, input logic b, input logic r);
    int n, np, k;
    logic press, grows;
    if (r) begin
      m_phase = 0; m_prev = 8'd0; m_btnq = 1'b0;
      e_rt16 = 0; e_rt4 = 0; e_b16 = 65535; e_b4 = 15;
      e_rv = 1'b0; e_js = 1'b0; e_se = 1'b0;
    end else begin
      press = b && !m_btnq;
      n     = $countones(l);
      np    = $countones(m_prev);
      grows = (l == therm(n)) && (n == np + 1);
      e_rv = 1'b0; e_js = 1'b0; e_se = 1'b0;
      case (m_phase)
        0: begin
          if (l == 8'd1 && m_prev == 8'd0) m_phase = 1;
        end
        1: begin
          if (press) begin e_js = 1'b1; m_phase = 0; end
          else if (l == m_prev) begin end
          else if (grows) begin if (n == 8) m_phase = 2; end
          else begin e_se = 1'b1; m_phase = 0; end
        end
        2: begin
          if (press) begin e_js = 1'b1; m_phase = 0; end
          else if (l == 8'd0) begin m_phase = 3; m_lo = m_cyc; end
          else if (l == m_prev) begin end
          else begin e_se = 1'b1; m_phase = 0; end
        end
        default: begin
          if (press) begin
            k = m_cyc - m_lo;
            e_rt16 = (k > 65535) ? 65535 : k;
            e_rt4  = (k > 15) ? 15 : k;
            e_rv   = 1'b1;
`ifdef F1_MON_BEST_EN
            if (e_rt16 < e_b16) e_b16 = e_rt16;
            if (e_rt4 < e_b4) e_b4 = e_rt4;
`endif
            m_phase = 0;
          end else if (l != 8'd0) begin
            e_se = 1'b1; m_phase = 0;
          end
        end
      endcase
      m_prev = l;
      m_btnq = b;
    end
    e_armed  = (m_phase == 1) || (m_phase == 2);
    e_timing = (m_phase == 3);
    m_cyc++;
  endtask

  // drive one cycle, advance the model, compare both instances after the edge
  task automatic tick(input logic [7:0] l, input logic b, input logic r);
    lights = l; btn = b; rst = r;
    @(posedge clk);
    model(l, b, r);
    #1;
    chk("armed",      {31'd0, armed16},  {31'd0, e_armed});
    chk("timing",     {31'd0, timing16}, {31'd0, e_timing});
    chk("result_vld", {31'd0, rv16},     {31'd0, e_rv});
    chk("jump_start", {31'd0, js16},     {31'd0, e_js});
    chk("seq_error",  {31'd0, se16},     {31'd0, e_se});
    chk("react16",    {16'd0, rt16},     e_rt16);
    chk("best16",     {16'd0, best16},   e_b16);
    chk("react4",     {28'd0, rt4},      e_rt4);
    chk("best4",      {28'd0, best4},    e_b4);
    chk("pulses4",    {29'd0, rv4, js4, se4}, {29'd0, e_rv, e_js, e_se});
    chk("state4",     {30'd0, armed4, timing4}, {30'd0, e_armed, e_timing});
  endtask

  // one light sequence; fault 0 none, 1 jump start, 2 skipped light,
  // 3 non-thermometer pattern, 4 relight while timing, 5 reset while timing
  task automatic run(input int fault, input int fpos, input int hmax, input int k);
    tick(8'd0, 1'b0, 1'b0);
    tick(8'd0, 1'b0, 1'b0);
    for (int n = 1; n <= 8; n++) begin
      for (int h = 0; h < ((hmax < 0) ? $urandom_range(1, 3) : hmax); h++)
        tick(therm(n), 1'b0, 1'b0);
      if (n == fpos) begin
        if (fault == 1) begin tick(therm(n), 1'b1, 1'b0); tick(therm(n), 1'b0, 1'b0); return; end
        if (fault == 2) begin tick(therm(n + 2), 1'b0, 1'b0); return; end
        if (fault == 3) begin tick(8'hA5, 1'b0, 1'b0); return; end
      end
    end
    tick(8'd0, 1'b0, 1'b0);
    for (int i = 1; i < k; i++) begin
      if (fault == 4 && i == k / 2) begin tick(8'd1, 1'b0, 1'b0); return; end
      if (fault == 5 && i == k / 2) begin tick(8'd0, 1'b0, 1'b1); return; end
      tick(8'd0, 1'b0, 1'b0);
    end
    tick(8'd0, 1'b1, 1'b0);
    tick(8'd0, 1'b0, 1'b0);
  endtask

  initial begin
    // reset
    tick(8'd0, 1'b0, 1'b1);
    tick(8'd0, 1'b0, 1'b1);
    chk("rst_react", {16'd0, rt16}, 32'd0);
    chk("rst_best",  {16'd0, best16}, 32'hFFFF);

    // legal run, two cycles per step, press 5 cycles after lights out
    run(0, 0, 2, 5);
    chk("t1_react", {16'd0, rt16}, 32'd5);

    // jump start with five lights lit; reaction_time holds
    run(1, 5, 2, 5);
    chk("t2_react_held", {16'd0, rt16}, 32'd5);

    // 1 -> 7 skip, then non-thermometer pattern while building
    tick(8'd0, 1'b0, 1'b0);
    tick(8'h01, 1'b0, 1'b0);
    tick(8'h07, 1'b0, 1'b0);
    tick(8'd0, 1'b0, 1'b0);
    tick(8'h01, 1'b0, 1'b0);
    tick(8'h03, 1'b0, 1'b0);
    tick(8'h05, 1'b0, 1'b0);

    // saturation in the 4-bit instance
    run(0, 0, 1, 20);
    chk("t4_sat4",  {28'd0, rt4}, 32'd15);
    chk("t4_full16", {16'd0, rt16}, 32'd20);

    // reset during timing aborts; next run measures normally
    run(5, 0, 1, 8);
    chk("t5_abort", {16'd0, rt16}, 32'd0);
    run(0, 0, 1, 6);
    chk("t5_after", {16'd0, rt16}, 32'd6);

    // best-time sequence after a fresh reset
    tick(8'd0, 1'b0, 1'b1);
    run(0, 0, 1, 9);
    run(0, 0, 1, 4);
    run(0, 0, 1, 7);
`ifdef F1_MON_BEST_EN
    chk("t6_best", {16'd0, best16}, 32'd4);
`else
    chk("t6_best", {16'd0, best16}, 32'hFFFF);
`endif

    // randomized runs
    for (int r = 0; r < 60; r++) begin
      run($urandom_range(0, 5), $urandom_range(1, 6), -1, $urandom_range(1, 24));
      if ($urandom_range(0, 3) == 0) begin
        tick(8'($urandom), 1'($urandom), 1'b0);
        tick(8'd0, 1'b0, 1'b0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
